execution_unit_muldiv: RTL

- Parametrised successor to the single-cycle execute stage of the 5-stage pipeline.
- Keeps the base RV32I ALU path as a single cycle and adds the RV32M operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) through an iterative multi-cycle multiply/divide engine.
- Raises a busy stall to the hazard unit while an M operation is in flight.
- Holds the JALR target and the M result stable across downstream stalls.

---
 rtl/execute_pkg.sv | 28 ++
 rtl/execute_alu.sv | 58 +++++
 rtl/muldiv_iterative.sv | 141 ++++++++++++++
 rtl/execution_unit_muldiv.sv | 108 ++++++++++
 4 files changed

// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage: mul/div FSM states, RV32M funct3 codes and ALU classes.
package execute_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } md_state_e;

  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Mulh   = 3'b001;
  localparam logic [2:0] F3Mulhsu = 3'b010;
  localparam logic [2:0] F3Mulhu  = 3'b011;
  localparam logic [2:0] F3Div    = 3'b100;
  localparam logic [2:0] F3Divu   = 3'b101;
  localparam logic [2:0] F3Rem    = 3'b110;
  localparam logic [2:0] F3Remu   = 3'b111;

  localparam logic [2:0] AluOpR      = 3'b000;
  localparam logic [2:0] AluOpI      = 3'b001;
  localparam logic [2:0] AluOpBranch = 3'b010;
  localparam logic [2:0] AluOpLui    = 3'b011;
  localparam logic [2:0] AluOpAdd    = 3'b100;

  localparam logic [6:0] Funct7M = 7'b0000001;

endpackage

// File: rtl/execute_alu.sv
// Single-cycle RV32I ALU: arithmetic/logic result plus branch condition.
module execute_alu import execute_pkg::*; #(
  parameter int unsigned Width = 32
) (
  input  logic [2:0]       alu_op_i,
  input  logic [2:0]       funct3_i,
  input  logic             alt_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] result_o,
  output logic             cond_o
);

  localparam int unsigned ShW = $clog2(Width);

  logic [ShW-1:0] shamt;
  logic           lt_s, lt_u, eq;

  assign shamt = b_i[ShW-1:0];
  assign lt_s  = $signed(a_i) < $signed(b_i);
  assign lt_u  = a_i < b_i;
  assign eq    = a_i == b_i;

  always_comb begin
    result_o = a_i + b_i;
    case (alu_op_i)
      AluOpR, AluOpI: begin
        case (funct3_i)
          3'b000:  result_o = (alu_op_i == AluOpR && alt_i) ? a_i - b_i : a_i + b_i;
          3'b001:  result_o = a_i << shamt;
          3'b010:  result_o = {{(Width-1){1'b0}}, lt_s};
          3'b011:  result_o = {{(Width-1){1'b0}}, lt_u};
          3'b100:  result_o = a_i ^ b_i;
          3'b101:  result_o = alt_i ? $unsigned($signed(a_i) >>> shamt) : a_i >> shamt;
          3'b110:  result_o = a_i | b_i;
          default: result_o = a_i & b_i;
        endcase
      end
      AluOpBranch: result_o = a_i - b_i;
      AluOpLui:    result_o = b_i;
      default:     ;
    endcase
  end

  always_comb begin
    cond_o = 1'b0;
    case (funct3_i)
      3'b000:  cond_o = eq;
      3'b001:  cond_o = ~eq;
      3'b100:  cond_o = lt_s;
      3'b101:  cond_o = ~lt_s;
      3'b110:  cond_o = lt_u;
      3'b111:  cond_o = ~lt_u;
      default: cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/muldiv_iterative.sv
// Iterative RV32M engine: one shift-add (multiply) or restoring-subtract (divide) step per cycle,
// operating on magnitudes with a sign fix-up applied to the finished accumulator.
module muldiv_iterative import execute_pkg::*; #(
  parameter int unsigned Width    = 32,
  parameter bit          EarlyOut = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] result_o
);

  localparam int unsigned CntW = $clog2(Width);

  md_state_e            state_q, state_d;
  logic [2*Width-1:0]   acc_q, acc_d;
  logic [Width-1:0]     b_q, b_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;

  logic                 a_signed, b_signed, a_neg, b_neg, b_zero, div_ovf;
  logic [Width-1:0]     mag_a, mag_b, min_val;
  logic [Width:0]       mul_sum, rem_shift, rem_diff;
  logic                 rem_ge;
  logic [2*Width-1:0]   prod;
  logic [Width-1:0]     div_val;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_i)
      F3Mul, F3Mulh, F3Div, F3Rem: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      F3Mulhsu: a_signed = 1'b1;
      default:  ;
    endcase
  end

  assign a_neg   = a_signed & a_i[Width-1];
  assign b_neg   = b_signed & b_i[Width-1];
  assign mag_a   = a_neg ? -a_i : a_i;
  assign mag_b   = b_neg ? -b_i : b_i;
  assign min_val = {1'b1, {(Width-1){1'b0}}};
  assign b_zero  = b_i == '0;
  assign div_ovf = b_signed & (a_i == min_val) & (b_i == '1);

  // Multiply: {hi, lo} with the multiplier in lo; divide: {remainder, dividend/quotient}.
  assign mul_sum   = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign rem_shift = acc_q[2*Width-1:Width-1];
  assign rem_ge    = rem_shift >= {1'b0, b_q};
  assign rem_diff  = rem_shift - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_o = start_i;
        if (start_i && !flush_i) begin
          acc_d = {{Width{1'b0}}, mag_a};
          b_d   = mag_b;
          op_d  = op_i;
          cnt_d = CntW'(Width - 1);
          if (!op_i[2]) begin
            state_d = StMul;
            neg_d   = a_neg ^ b_neg;
          end else begin
            state_d = StDiv;
            neg_d   = op_i[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero);
            // Early-out loads the final magnitudes so the shared fix-up still applies.
            if (EarlyOut && b_zero) begin
              acc_d   = {mag_a, {Width{1'b1}}};
              state_d = StDone;
            end else if (EarlyOut && div_ovf) begin
              acc_d   = {{Width{1'b0}}, min_val};
              state_d = StDone;
            end
          end
        end
      end
      StMul, StDiv: begin
        busy_o = 1'b1;
        if (state_q == StMul) begin
          acc_d = {mul_sum, acc_q[Width-1:1]};
        end else begin
          acc_d = {(rem_ge ? rem_diff[Width-1:0] : rem_shift[Width-1:0]),
                   acc_q[Width-2:0], rem_ge};
        end
        if (cnt_q == '0) state_d = StDone;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      StDone: begin
        done_o = 1'b1;
        if (!hold_i) state_d = StIdle;
      end
    endcase
    if (flush_i) state_d = StIdle;
  end

  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    div_val = op_q[1] ? acc_q[2*Width-1:Width] : acc_q[Width-1:0];
    if (!op_q[2]) result_o = (op_q[1:0] == 2'b00) ? prod[Width-1:0] : prod[2*Width-1:Width];
    else          result_o = neg_q ? -div_val : div_val;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
    end
  end

endmodule

// File: rtl/execution_unit_muldiv.sv
// Execute stage: single-cycle RV32I ALU plus iterative RV32M engine, with result and JALR muxing.
module execution_unit_muldiv import execute_pkg::*; #(
  parameter int unsigned CORE         = 0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDRESS_BITS = 20,
  parameter bit          EARLY_OUT    = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    flush,
  input  logic                    valid_in,
  input  logic [2:0]              ALU_Operation,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic [ADDRESS_BITS-1:0] PC,
  input  logic [1:0]              ALU_ASrc,
  input  logic                    ALU_BSrc,
  input  logic                    branch_op,
  input  logic [DATA_WIDTH-1:0]   regRead_1,
  input  logic [DATA_WIDTH-1:0]   regRead_2,
  input  logic [DATA_WIDTH-1:0]   extend,
  input  logic                    report,
  output logic [DATA_WIDTH-1:0]   ALU_result,
  output logic                    zero,
  output logic                    branch,
  output logic [ADDRESS_BITS-1:0] JALR_target,
  output logic                    busy,
  output logic                    valid_out
);

  logic                    is_m, md_busy, md_done, alu_cond;
  logic [DATA_WIDTH-1:0]   op_a, op_b, alu_result, md_result;
  logic [ADDRESS_BITS-1:0] jalr_sum, jalr_live;
  logic [ADDRESS_BITS-1:0] old_jalr_q, old_jalr_d;
  logic                    old_stall_q, old_stall_d;

  assign is_m = valid_in & (ALU_Operation == AluOpR) & (funct7 == Funct7M);

  always_comb begin
    case (ALU_ASrc)
      2'b01:   op_a = DATA_WIDTH'(PC);
      2'b10:   op_a = DATA_WIDTH'(PC) + DATA_WIDTH'(4);
      default: op_a = regRead_1;
    endcase
  end
  assign op_b = ALU_BSrc ? extend : regRead_2;

  execute_alu #(
    .Width(DATA_WIDTH)
  ) u_alu (
    .alu_op_i(ALU_Operation),
    .funct3_i(funct3),
    .alt_i   (funct7[5]),
    .a_i     (op_a),
    .b_i     (op_b),
    .result_o(alu_result),
    .cond_o  (alu_cond)
  );

  muldiv_iterative #(
    .Width   (DATA_WIDTH),
    .EarlyOut(EARLY_OUT)
  ) u_muldiv (
    .clk_i   (clock),
    .rst_ni  (reset),
    .start_i (is_m),
    .op_i    (funct3),
    .a_i     (regRead_1),
    .b_i     (regRead_2),
    .flush_i (flush),
    .hold_i  (stall),
    .busy_o  (md_busy),
    .done_o  (md_done),
    .result_o(md_result)
  );

  assign ALU_result = md_done ? md_result : alu_result;
  assign zero       = alu_result == '0;
  assign branch     = branch_op & alu_cond;
  // Reset masks the combinational issue term so the hazard unit sees no stall while held.
  assign busy       = reset & md_busy;
  assign valid_out  = reset & (md_done | (valid_in & ~is_m));

  assign jalr_sum    = ADDRESS_BITS'(regRead_1 + extend);
  assign jalr_live   = jalr_sum & ~ADDRESS_BITS'(1);
  assign JALR_target = old_stall_q ? old_jalr_q : jalr_live;

  always_comb begin
    old_jalr_d  = JALR_target;
    old_stall_d = stall;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      old_jalr_q  <= '0;
      old_stall_q <= 1'b0;
    end else begin
      old_jalr_q  <= old_jalr_d;
      old_stall_q <= old_stall_d;
    end
  end

  // The per-cycle dump is a simulation aid with no hardware behind it.
  logic unused_dbg;
  assign unused_dbg = ^{report, 32'(CORE)};

endmodule
